// File: rtl/axi_buf_pkg.sv
// Shared types and helpers for the AXI read-data return buffer.
package axi_buf_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_EXOKAY = 2'b01;
   localparam axi_resp_t RESP_SLVERR = 2'b10;
   localparam axi_resp_t RESP_DECERR = 2'b11;

   // Low-order part of a stored entry; MASTER/ID/DATA are prepended by the top.
   typedef struct packed {
      axi_resp_t resp;
      logic      last;
   } r_tail_t;

   function automatic r_tail_t make_tail(input logic last, input axi_resp_t resp);
      r_tail_t t;
      t.resp = resp;
      t.last = last;
      return t;
   endfunction

endpackage

// File: rtl/axi_buf_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module axi_buf_ram #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry on an accepted beat
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axi_rdata_buffer.sv
// AXI read-data return buffer: first-word fall-through FIFO carrying
// MASTER/ID/DATA/RESP/LAST, with occupancy (COUNT) and buffered-LAST (BURSTS) counters.
// Define AXI_RDATA_STORE_FWD_EN to hold a burst until its LAST beat is buffered;
// otherwise the buffer is pure cut-through.
module axi_rdata_buffer
   import axi_buf_pkg::*;
#(
   parameter int unsigned MASTERS    = 4,
   parameter int unsigned ID_BITS    = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic [MASTERS-1:0]    MASTER,
   input  logic [ID_BITS-1:0]    ID,
   input  logic [DATA_WIDTH-1:0] DATA,
   input  logic [1:0]            RESP,
   input  logic                  LAST,
   input  logic                  VALID,
   output logic                  READY,
   output logic [MASTERS-1:0]    O_MASTER,
   output logic [ID_BITS-1:0]    O_ID,
   output logic [DATA_WIDTH-1:0] O_DATA,
   output logic [1:0]            O_RESP,
   output logic                  O_LAST,
   output logic                  O_VALID,
   input  logic                  O_READY,
   output logic [CW-1:0]         COUNT,
   output logic [CW-1:0]         BURSTS
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = MASTERS + ID_BITS + DATA_WIDTH + $bits(r_tail_t);

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] bursts_q, bursts_d;
   logic          ready_q;
   logic          push, pop, o_valid;

   logic [EW-1:0]         wr_entry, rd_entry;
   logic [MASTERS-1:0]    head_master;
   logic [ID_BITS-1:0]    head_id;
   logic [DATA_WIDTH-1:0] head_data;
   r_tail_t               head_tail;

   assign wr_entry = {MASTER, ID, DATA, make_tail(LAST, RESP)};
   assign {head_master, head_id, head_data, head_tail} = rd_entry;

   axi_buf_ram #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (CLK),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   // READY is registered, so a pop while full does not admit a push in the same cycle
   assign push = VALID && ready_q;
   assign pop  = o_valid && O_READY;

   // Next occupancy and buffered-LAST counts
   always_comb begin
      count_d  = count_q;
      bursts_d = bursts_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push && LAST) begin
         bursts_d = bursts_d + CW'(1);
      end
      if (pop && head_tail.last) begin
         bursts_d = bursts_d - CW'(1);
      end
   end

   // Pointers, counters and READY; reset discards everything buffered
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bursts_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q  <= count_d;
         bursts_q <= bursts_d;
         ready_q  <= (count_d != CW'(DEPTH));
      end
   end

`ifdef AXI_RDATA_STORE_FWD_EN
   // sf_open_q keeps a released burst flowing until its LAST beat leaves
   logic sf_open_q;

   // Track whether the head burst has started leaving
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sf_open_q <= 1'b0;
      end else if (pop) begin
         sf_open_q <= !head_tail.last;
      end
   end

   // Full-buffer term releases bursts longer than DEPTH instead of deadlocking
   assign o_valid = (count_q != '0) &&
                    (sf_open_q || (bursts_q != '0) || (count_q == CW'(DEPTH)));
`else
   assign o_valid = (count_q != '0);
`endif

   assign READY    = ready_q;
   assign O_VALID  = o_valid;
   assign COUNT    = count_q;
   assign BURSTS   = bursts_q;
   assign O_MASTER = o_valid ? head_master : '0;
   assign O_ID     = o_valid ? head_id : '0;
   assign O_DATA   = o_valid ? head_data : '0;
   assign O_RESP   = o_valid ? head_tail.resp : RESP_OKAY;
   assign O_LAST   = o_valid ? head_tail.last : 1'b0;

endmodule

// File: tb/tb_axi_rdata_buffer.sv
// Scoreboard bench for axi_rdata_buffer (DEPTH=8). Store-and-forward cases run only
// when AXI_RDATA_STORE_FWD_EN is defined.
module tb_axi_rdata_buffer;

   typedef struct packed {
      logic [3:0]  m;
      logic [1:0]  id;
      logic [63:0] d;
      logic [1:0]  r;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  master = '0;
   logic [1:0]  id = '0;
   logic [63:0] data = '0;
   logic [1:0]  resp = '0;
   logic        last = 1'b0;
   logic        valid = 1'b0;
   logic        ready;
   logic [3:0]  o_master;
   logic [1:0]  o_id;
   logic [63:0] o_data;
   logic [1:0]  o_resp;
   logic        o_last;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [3:0]  count;
   logic [3:0]  bursts;

   int total = 0;
   int bad = 0;
   beat_t q[$];

   axi_rdata_buffer #(
      .MASTERS    (4),
      .ID_BITS    (2),
      .DATA_WIDTH (64),
      .DEPTH      (8)
   ) dut (
      .CLK      (clk),
      .RESETN   (rst_n),
      .MASTER   (master),
      .ID       (id),
      .DATA     (data),
      .RESP     (resp),
      .LAST     (last),
      .VALID    (valid),
      .READY    (ready),
      .O_MASTER (o_master),
      .O_ID     (o_id),
      .O_DATA   (o_data),
      .O_RESP   (o_resp),
      .O_LAST   (o_last),
      .O_VALID  (o_valid),
      .O_READY  (o_ready),
      .COUNT    (count),
      .BURSTS   (bursts)
   );

   always #5 clk = ~clk;

   // Input side: every accepted beat becomes an expected output beat
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         q.push_back('{m: master, id: id, d: data, r: resp, l: last});
      end
   end

   // Output side: every beat taken downstream must match the oldest expectation
   always @(negedge clk) begin
      beat_t got, exp;
      if (rst_n && o_valid && o_ready) begin
         got = '{m: o_master, id: o_id, d: o_data, r: o_resp, l: o_last};
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected got=%h want=none", got);
         end else begin
            exp = q.pop_front();
            if (got !== exp) begin
               bad++;
               $display("FAIL beat got=%h want=%h", got, exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
      data   = d;
      resp   = r;
      last   = l;
      id     = d[1:0];
      master = 4'b0001 << d[1:0];
      valid  = 1'b1;
   endtask

   // Offer one beat and hold it until accepted (bounded)
   task automatic put(input logic [63:0] d, input logic [1:0] r, input logic l);
      bit ok;
      ok = 1'b0;
      set_beat(d, r, l);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL put_timeout got=ready0 want=ready1");
      end
      tick();
      valid = 1'b0;
   endtask

   task automatic drain();
      o_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (count == 0) break;
         tick();
      end
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_queue", 64'(q.size()), 64'd0);
      chk("drain_bursts", 64'(bursts), 64'd0);
      tick();
      o_ready = 1'b0;
   endtask

   initial begin
      // 1 Reset held with VALID high
      #1;
      rst_n = 1'b0;
      set_beat(64'hAA, 2'b00, 1'b1);
      repeat (3) tick();
      @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_ovalid", 64'(o_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_odata", o_data, 64'd0);
      rst_n = 1'b1;
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("rel_ready", 64'(ready), 64'd1);
      chk("rel_count", 64'(count), 64'd0);
      chk("rel_ovalid", 64'(o_valid), 64'd0);
      tick();

      // 2 Fill to DEPTH, ninth beat refused, then in-order drain
      for (int i = 0; i < 8; i++) begin
         put(64'(i), 2'(i), (i == 7));
      end
      set_beat(64'd8, 2'b00, 1'b0);
      @(negedge clk);
      chk("full_count", 64'(count), 64'd8);
      chk("full_ready", 64'(ready), 64'd0);
      chk("full_bursts", 64'(bursts), 64'd1);
      chk("full_ovalid", 64'(o_valid), 64'd1);
      chk("full_head", o_data, 64'd0);
      tick();
      @(negedge clk);
      chk("full_hold_count", 64'(count), 64'd8);
      tick();
      valid = 1'b0;
      drain();

      // 3 Simultaneous push/pop at COUNT=4 across pointer wraps
      for (int i = 0; i < 4; i++) begin
         put(64'(100 + i), 2'b01, (i == 3));
      end
      for (int k = 0; k < 20; k++) begin
         set_beat(64'(104 + k), 2'b00, (k % 4 == 3));
         o_ready = 1'b1;
         @(negedge clk);
         chk("sim_count", 64'(count), 64'd4);
         tick();
      end
      valid = 1'b0;
      drain();

      // 4 Full plus pop: pop only, READY returns next cycle
      for (int i = 0; i < 8; i++) begin
         put(64'(200 + i), 2'b11, (i == 3 || i == 7));
      end
      set_beat(64'd208, 2'b00, 1'b1);
      o_ready = 1'b1;
      @(negedge clk);
      chk("fp_ready0", 64'(ready), 64'd0);
      chk("fp_count8", 64'(count), 64'd8);
      tick();
      o_ready = 1'b0;
      @(negedge clk);
      chk("fp_count7", 64'(count), 64'd7);
      chk("fp_ready1", 64'(ready), 64'd1);
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("fp_refill", 64'(count), 64'd8);
      tick();
      drain();

`ifdef AXI_RDATA_STORE_FWD_EN
      // 5 Burst held until LAST buffered, then leaves back-to-back
      o_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         put(64'(300 + i), 2'b00, 1'b0);
         @(negedge clk);
         chk("sf_hold", 64'(o_valid), 64'd0);
         chk("sf_hold_count", 64'(count), 64'(i + 1));
         tick();
      end
      set_beat(64'd303, 2'b00, 1'b1);
      @(negedge clk);
      chk("sf_pre_last", 64'(o_valid), 64'd0);
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("sf_bursts1", 64'(bursts), 64'd1);
      chk("sf_count4", 64'(count), 64'd4);
      chk("sf_rel0", 64'(o_valid), 64'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         @(negedge clk);
         chk("sf_stream", 64'(o_valid), 64'd1);
      end
      tick();
      @(negedge clk);
      chk("sf_bursts0", 64'(bursts), 64'd0);
      chk("sf_empty", 64'(count), 64'd0);
      tick();
      o_ready = 1'b0;

      // 6 Burst longer than DEPTH released by the full fallback
      o_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         put(64'(400 + i), (i == 5) ? 2'b10 : 2'b00, 1'b0);
      end
      @(negedge clk);
      chk("ov_hold", 64'(o_valid), 64'd0);
      chk("ov_count7", 64'(count), 64'd7);
      tick();
      for (int i = 7; i < 12; i++) begin
         put(64'(400 + i), 2'b00, (i == 11));
      end
      drain();
`endif

      // Reset mid-transfer discards buffered beats
      for (int i = 0; i < 3; i++) begin
         put(64'(500 + i), 2'b00, 1'b0);
      end
      rst_n = 1'b0;
      q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      o_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_ovalid", 64'(o_valid), 64'd0);
      tick();
      o_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
